ex_mul_iter: RTL and testbench
==============================

Name: ex_mul_iter

Overview:
- Parametrised iterative integer multiplier for the EX stage; successor to the 1-bit-per-cycle shift-add multiplier.
- Executes RV32M MUL/MULH/MULHSU/MULHU, retiring BITS_PER_CYC multiplier bits per cycle.
- Adds kill (pipeline flush) and a result-hold handshake so the writeback arbiter can back-pressure.
- Tags the result with the destination register address captured at issue.

Parameters:
- XLEN, 32: operand/result width.
- BITS_PER_CYC, 1: multiplier bits consumed per iteration. Legal values are 1, 2, 4, 8; must divide XLEN.
- ADDR_W, 5: register address width.

Ports:
- clk, input, 1: clock. One clock domain; all state updates on its rising edge.
- rstn, input, 1: asynchronous, active-low reset.
- mul_start_i, input, 1: issue request. Sampled only in IDLE.
- mul_kill_i, input, 1: flush; aborts any in-flight or held operation.
- mul_multiplicand_i, input, XLEN: rs1 value.
- mul_multiplier_i, input, XLEN: rs2 value.
- mul_op_i, input, 3: funct3. 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU.
- mul_reg_waddr_i, input, ADDR_W: destination register.
- mul_ack_i, input, 1: consumer accepts the result.
- mul_busy_o, output, 1: high in CALC and DONE.
- mul_ready_o, output, 1: result valid; high only in DONE.
- mul_res_o, output, XLEN: result. Zero unless mul_ready_o is high.
- mul_reg_waddr_o, output, ADDR_W: captured destination register. Zero unless mul_ready_o is high.

Behaviour:
- Reset: state IDLE; all outputs 0; accumulator, operand registers, count, op and sign registers all 0.
- States: IDLE, CALC, DONE. N = XLEN/BITS_PER_CYC.
- IDLE:
  - Accept when mul_start_i=1, mul_kill_i=0 and mul_op_i[2]=0.
  - On accept, latch operand magnitudes, op, waddr and neg flag; clear the 2*XLEN accumulator; count=0; go to CALC.
  - Illegal op (bit2=1) is ignored and the block stays in IDLE.
- Operand magnitudes:
  - MULH: two's-complement absolute value of both operands.
  - MULHSU: absolute value of rs1 only.
  - MUL, MULHU: raw values.
  - The most-negative value 0x80000000 has magnitude 2^31 unsigned; no overflow.
- neg flag:
  - MULH: rs1[XLEN-1] ^ rs2[XLEN-1].
  - MULHSU: rs1[XLEN-1].
  - Otherwise 0.
- CALC: each cycle
  - acc += mcand_mag * mplier[BITS_PER_CYC-1:0], shifted left by count*BITS_PER_CYC;
  - mplier >>= BITS_PER_CYC;
  - count++.
  - After the N-th iteration, go to DONE. Fixed latency: accept edge + N cycles, then mul_ready_o rises.
- DONE: let P = neg ? (~acc + 1) : acc.
  - MUL: P[XLEN-1:0].
  - MULH, MULHSU, MULHU: P[2*XLEN-1:XLEN].
  - Result and waddr are held stable while mul_ack_i=0.
  - mul_ack_i=1 returns to IDLE on the next edge. A new start is not accepted in that same cycle.
- Back-to-back operations: minimum issue interval is N+2 cycles.
- mul_start_i while busy: ignored, no effect.
- mul_kill_i=1 in any state: IDLE on the next edge; mul_ready_o=0 from that edge; result discarded. Kill takes priority over start and over ack.
- Reset asserted mid-operation: immediate return to the reset values above.

Optional Feature:
- Macro MUL_EARLY_OUT_EN.
- Defined:
  - On accept, if either operand magnitude is 0, go directly to DONE with acc=0 (latency 1).
  - In CALC, if the remaining shifted multiplier is 0 after an iteration, go to DONE early.
  - Results are bit-identical to the fixed-latency path; only mul_ready_o timing differs.
- Undefined: always exactly N CALC cycles.

Decomposition:
- Shared defines file (existing core defines): INST_MUL/MULH/MULHSU/MULHU funct3 encodings, ZeroWord, RstEnable, RegBus/RegAddrBus.
- State encodings stay local to the module.
- One sub-module, ex_mul_step: combinational partial-product-and-accumulate for one BITS_PER_CYC slice (inputs acc, mcand, digit, shift; output new acc). Lets a radix change touch only that unit.

Test Plan:
- MUL 7 x 6, BITS_PER_CYC=1: ready after 32 CALC cycles, res 0x0000002A, waddr echoed.
- MULH 0x80000000 x 0x80000000 -> 0x40000000. MULH 0xFFFFFFFF x 0x00000002 -> 0xFFFFFFFF.
- MULHSU 0xFFFFFFFF x 0xFFFFFFFF -> 0xFFFFFFFF. MULHU 0xFFFFFFFF x 0xFFFFFFFF -> 0xFFFFFFFE.
- Hold ack low for 5 cycles in DONE: res and waddr stable, busy=1. Raise ack: IDLE next cycle. A second start in the ack cycle is ignored.
- Kill at CALC count=10: ready never rises, busy=0 next cycle. Restart MUL 3 x 5 -> 0x0000000F with no residue from the killed op.
- BITS_PER_CYC=4: MULHU 0x12345678 x 0x9ABCDEF0 -> 0x0B00EA4E after 8 CALC cycles. With MUL_EARLY_OUT_EN: MUL 0 x 5 -> ready 1 cycle after accept, res 0.

Source files
------------

// File: rtl/ex_mul_iter_pkg.sv
// ex_mul_iter_pkg: RV32M multiply funct3 encodings shared by the EX-stage multiplier.
package ex_mul_iter_pkg;
  localparam logic [2:0] INST_MUL    = 3'b000;
  localparam logic [2:0] INST_MULH   = 3'b001;
  localparam logic [2:0] INST_MULHSU = 3'b010;
  localparam logic [2:0] INST_MULHU  = 3'b011;
endpackage

// File: rtl/ex_mul_iter_if.sv
// ex_mul_iter_if: issue/result handshake between the EX stage and the iterative multiplier.
interface ex_mul_iter_if #(parameter int XLEN = 32, parameter int ADDR_W = 5);
  logic              mul_start_i;
  logic              mul_kill_i;
  logic [XLEN-1:0]   mul_multiplicand_i;
  logic [XLEN-1:0]   mul_multiplier_i;
  logic [2:0]        mul_op_i;
  logic [ADDR_W-1:0] mul_reg_waddr_i;
  logic              mul_ack_i;
  logic              mul_busy_o;
  logic              mul_ready_o;
  logic [XLEN-1:0]   mul_res_o;
  logic [ADDR_W-1:0] mul_reg_waddr_o;
  modport master (
    output mul_start_i, mul_kill_i, mul_multiplicand_i, mul_multiplier_i, mul_op_i, mul_reg_waddr_i, mul_ack_i,
    input  mul_busy_o, mul_ready_o, mul_res_o, mul_reg_waddr_o
  );
  modport slave (
    input  mul_start_i, mul_kill_i, mul_multiplicand_i, mul_multiplier_i, mul_op_i, mul_reg_waddr_i, mul_ack_i,
    output mul_busy_o, mul_ready_o, mul_res_o, mul_reg_waddr_o
  );
endinterface

// File: rtl/ex_mul_step.sv
// ex_mul_step: one radix-2^BITS_PER_CYC partial product added into the double-width accumulator.
module ex_mul_step #(
  parameter int XLEN         = 32,
  parameter int BITS_PER_CYC = 1,
  parameter int SW           = $clog2(2*XLEN)
) (
  input  logic [2*XLEN-1:0]       acc_i,
  input  logic [XLEN-1:0]         mcand_i,
  input  logic [BITS_PER_CYC-1:0] digit_i,
  input  logic [SW-1:0]           shift_i,
  output logic [2*XLEN-1:0]       acc_o
);
  assign acc_o = acc_i + (((2*XLEN)'(mcand_i) * (2*XLEN)'(digit_i)) << shift_i);
endmodule

// File: rtl/ex_mul_iter.sv
// ex_mul_iter: iterative RV32M MUL/MULH/MULHSU/MULHU on operand magnitudes with sign fix-up at the end.
// MUL_EARLY_OUT_EN: finish as soon as the remaining multiplier is zero.
module ex_mul_iter
  import ex_mul_iter_pkg::*;
#(
  parameter int XLEN         = 32,
  parameter int BITS_PER_CYC = 1,
  parameter int ADDR_W       = 5
) (
  input logic          clk,
  input logic          rstn,
  ex_mul_iter_if.slave mul
);
  localparam int N  = XLEN / BITS_PER_CYC;
  localparam int CW = $clog2(N) + 1;
  localparam int SW = $clog2(2*XLEN);
  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;
  state_t            state_q, state_d;
  logic [2*XLEN-1:0] acc_q, acc_d, acc_step, prod;
  logic [XLEN-1:0]   mcand_q, mcand_d, mplier_q, mplier_d, a_mag, b_mag;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [2:0]        op_q, op_d;
  logic              neg_q, neg_d;
  logic [ADDR_W-1:0] waddr_q, waddr_d;
  logic [SW-1:0]     sh;
  logic              a_neg, b_neg;
  assign a_neg = (mul.mul_op_i == INST_MULH || mul.mul_op_i == INST_MULHSU) && mul.mul_multiplicand_i[XLEN-1];
  assign b_neg = (mul.mul_op_i == INST_MULH) && mul.mul_multiplier_i[XLEN-1];
  assign a_mag = a_neg ? -mul.mul_multiplicand_i : mul.mul_multiplicand_i;
  assign b_mag = b_neg ? -mul.mul_multiplier_i : mul.mul_multiplier_i;
  assign sh    = SW'(cnt_q) * SW'(BITS_PER_CYC);
  ex_mul_step #(.XLEN(XLEN), .BITS_PER_CYC(BITS_PER_CYC), .SW(SW)) u_step (
    .acc_i  (acc_q),
    .mcand_i(mcand_q),
    .digit_i(mplier_q[BITS_PER_CYC-1:0]),
    .shift_i(sh),
    .acc_o  (acc_step)
  );
  always_comb begin
    state_d  = state_q;
    acc_d    = acc_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    cnt_d    = cnt_q;
    op_d     = op_q;
    neg_d    = neg_q;
    waddr_d  = waddr_q;
    if (mul.mul_kill_i) begin
      state_d = IDLE;
    end else if (state_q == IDLE && mul.mul_start_i && !mul.mul_op_i[2]) begin
      state_d  = CALC;
      acc_d    = '0;
      mcand_d  = a_mag;
      mplier_d = b_mag;
      cnt_d    = '0;
      op_d     = mul.mul_op_i;
      neg_d    = a_neg ^ b_neg;
      waddr_d  = mul.mul_reg_waddr_i;
`ifdef MUL_EARLY_OUT_EN
      if (a_mag == '0 || b_mag == '0) state_d = DONE;
`endif
    end else if (state_q == CALC) begin
      acc_d    = acc_step;
      mplier_d = mplier_q >> BITS_PER_CYC;
      cnt_d    = cnt_q + 1'b1;
      if (cnt_q == CW'(N-1)) state_d = DONE;
`ifdef MUL_EARLY_OUT_EN
      if (mplier_d == '0) state_d = DONE;
`endif
    end else if (state_q == DONE && mul.mul_ack_i) begin
      state_d = IDLE;
    end
  end
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q  <= IDLE;
      acc_q    <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
      cnt_q    <= '0;
      op_q     <= '0;
      neg_q    <= 1'b0;
      waddr_q  <= '0;
    end else begin
      state_q  <= state_d;
      acc_q    <= acc_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      cnt_q    <= cnt_d;
      op_q     <= op_d;
      neg_q    <= neg_d;
      waddr_q  <= waddr_d;
    end
  end
  assign prod                = neg_q ? -acc_q : acc_q;
  assign mul.mul_busy_o      = state_q != IDLE;
  assign mul.mul_ready_o     = state_q == DONE;
  assign mul.mul_res_o       = !mul.mul_ready_o ? '0 : (op_q == INST_MUL) ? prod[XLEN-1:0] : prod[2*XLEN-1:XLEN];
  assign mul.mul_reg_waddr_o = mul.mul_ready_o ? waddr_q : '0;
endmodule

// File: tb/tb_ex_mul_iter.sv
// tb_ex_mul_iter: directed checks of a radix-2 and a radix-16 instance of ex_mul_iter.
module tb_ex_mul_iter;
  logic clk = 1'b0;
  logic rstn = 1'b0;
  int ncmp = 0;
  int nfail = 0;
`ifdef MUL_EARLY_OUT_EN
  localparam bit EO = 1'b1;
`else
  localparam bit EO = 1'b0;
`endif
  always #5 clk = ~clk;
  ex_mul_iter_if #(.XLEN(32), .ADDR_W(5)) ifa ();
  ex_mul_iter_if #(.XLEN(32), .ADDR_W(5)) ifb ();
  ex_mul_iter #(.XLEN(32), .BITS_PER_CYC(1), .ADDR_W(5)) dut_a (.clk(clk), .rstn(rstn), .mul(ifa));
  ex_mul_iter #(.XLEN(32), .BITS_PER_CYC(4), .ADDR_W(5)) dut_b (.clk(clk), .rstn(rstn), .mul(ifb));

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    ncmp++;
    assert (got === exp) else begin
      nfail++;
      $error("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic int exp_lat(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b, input int bpc);
    logic [31:0] am, bm;
    int n;
    am = ((op == 3'b001 || op == 3'b010) && a[31]) ? -a : a;
    bm = (op == 3'b001 && b[31]) ? -b : b;
    if (!EO) return 32 / bpc;
    if (am == 0 || bm == 0) return 0;
    n = 0;
    while (bm != 0) begin
      bm = bm >> bpc;
      n++;
    end
    return n;
  endfunction

  task automatic drive(input bit sel, input bit st, input logic [2:0] op, input logic [31:0] a, input logic [31:0] b, input logic [4:0] wa);
    if (sel) begin
      ifb.mul_start_i = st; ifb.mul_op_i = op; ifb.mul_multiplicand_i = a; ifb.mul_multiplier_i = b; ifb.mul_reg_waddr_i = wa;
    end else begin
      ifa.mul_start_i = st; ifa.mul_op_i = op; ifa.mul_multiplicand_i = a; ifa.mul_multiplier_i = b; ifa.mul_reg_waddr_i = wa;
    end
  endtask

  task automatic issue(input bit sel, input logic [2:0] op, input logic [31:0] a, input logic [31:0] b, input logic [4:0] wa);
    drive(sel, 1'b1, op, a, b, wa);
    @(negedge clk);
    drive(sel, 1'b0, 3'b000, 32'h0, 32'h0, 5'h0);
  endtask

  task automatic wait_ready(input bit sel, output int lat);
    lat = 0;
    while (!(sel ? ifb.mul_ready_o : ifa.mul_ready_o) && lat < 100) begin
      @(negedge clk);
      lat++;
    end
  endtask

  task automatic do_ack(input bit sel);
    if (sel) ifb.mul_ack_i = 1'b1; else ifa.mul_ack_i = 1'b1;
    @(negedge clk);
    if (sel) ifb.mul_ack_i = 1'b0; else ifa.mul_ack_i = 1'b0;
  endtask

  task automatic run(input bit sel, input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                     input logic [4:0] wa, input logic [31:0] exp_res, input string tag);
    int lat;
    issue(sel, op, a, b, wa);
    wait_ready(sel, lat);
    check({tag, ".lat"}, 64'(lat), 64'(exp_lat(op, a, b, sel ? 4 : 1)));
    check({tag, ".res"}, 64'(sel ? ifb.mul_res_o : ifa.mul_res_o), 64'(exp_res));
    check({tag, ".waddr"}, 64'(sel ? ifb.mul_reg_waddr_o : ifa.mul_reg_waddr_o), 64'(wa));
    do_ack(sel);
    check({tag, ".idle"}, 64'(sel ? ifb.mul_busy_o : ifa.mul_busy_o), 64'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat;
    bit seen;
    ifa.mul_kill_i = 1'b0; ifa.mul_ack_i = 1'b0;
    ifb.mul_kill_i = 1'b0; ifb.mul_ack_i = 1'b0;
    drive(1'b0, 1'b0, 3'b000, 32'h0, 32'h0, 5'h0);
    drive(1'b1, 1'b0, 3'b000, 32'h0, 32'h0, 5'h0);
    repeat (3) @(negedge clk);
    check("rst.busy", 64'(ifa.mul_busy_o), 64'd0);
    check("rst.ready", 64'(ifa.mul_ready_o), 64'd0);
    check("rst.res", 64'(ifa.mul_res_o), 64'd0);
    check("rst.waddr", 64'(ifa.mul_reg_waddr_o), 64'd0);
    check("rst.b_busy", 64'(ifb.mul_busy_o), 64'd0);
    rstn = 1'b1;
    @(negedge clk);

    run(1'b0, 3'b000, 32'd7, 32'd6, 5'd9, 32'h0000002A, "mul_7x6");
    run(1'b0, 3'b001, 32'h80000000, 32'h80000000, 5'd3, 32'h40000000, "mulh_min");
    run(1'b0, 3'b001, 32'hFFFFFFFF, 32'h00000002, 5'd4, 32'hFFFFFFFF, "mulh_neg");
    run(1'b0, 3'b010, 32'hFFFFFFFF, 32'hFFFFFFFF, 5'd5, 32'hFFFFFFFF, "mulhsu");
    run(1'b0, 3'b011, 32'hFFFFFFFF, 32'hFFFFFFFF, 5'd6, 32'hFFFFFFFE, "mulhu");
    run(1'b0, 3'b000, 32'hFFFFFFFD, 32'd5, 5'd8, 32'hFFFFFFF1, "mul_neg");

    issue(1'b0, 3'b100, 32'd7, 32'd6, 5'd1);
    check("illegal.busy", 64'(ifa.mul_busy_o), 64'd0);

    issue(1'b0, 3'b000, 32'd7, 32'd6, 5'd17);
    wait_ready(1'b0, lat);
    check("hold.lat", 64'(lat), 64'(exp_lat(3'b000, 32'd7, 32'd6, 1)));
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("hold.res", 64'(ifa.mul_res_o), 64'h2A);
      check("hold.waddr", 64'(ifa.mul_reg_waddr_o), 64'd17);
      check("hold.busy", 64'(ifa.mul_busy_o), 64'd1);
    end
    drive(1'b0, 1'b1, 3'b000, 32'd2, 32'd2, 5'd2);
    ifa.mul_ack_i = 1'b1;
    @(negedge clk);
    ifa.mul_ack_i = 1'b0;
    drive(1'b0, 1'b0, 3'b000, 32'h0, 32'h0, 5'h0);
    check("ack.busy", 64'(ifa.mul_busy_o), 64'd0);
    check("ack.ready", 64'(ifa.mul_ready_o), 64'd0);
    check("ack.res", 64'(ifa.mul_res_o), 64'd0);
    @(negedge clk);
    check("ack.no_restart", 64'(ifa.mul_busy_o), 64'd0);

    issue(1'b0, 3'b000, 32'd9, 32'hFFFFFFFF, 5'd7);
    repeat (10) @(negedge clk);
    check("kill.pre_busy", 64'(ifa.mul_busy_o), 64'd1);
    ifa.mul_kill_i = 1'b1;
    @(negedge clk);
    ifa.mul_kill_i = 1'b0;
    check("kill.busy", 64'(ifa.mul_busy_o), 64'd0);
    check("kill.ready", 64'(ifa.mul_ready_o), 64'd0);
    seen = 1'b0;
    repeat (40) begin
      @(negedge clk);
      if (ifa.mul_ready_o) seen = 1'b1;
    end
    check("kill.never_ready", 64'(seen), 64'd0);
    run(1'b0, 3'b000, 32'd3, 32'd5, 5'd11, 32'h0000000F, "restart_3x5");

    issue(1'b0, 3'b000, 32'd7, 32'hFFFFFFFF, 5'd12);
    repeat (5) @(negedge clk);
    #2 rstn = 1'b0;
    #1;
    check("arst.busy", 64'(ifa.mul_busy_o), 64'd0);
    @(negedge clk);
    rstn = 1'b1;
    @(negedge clk);
    check("arst.idle", 64'(ifa.mul_busy_o), 64'd0);

    run(1'b1, 3'b011, 32'h12345678, 32'h9ABCDEF0, 5'd21, 32'h0B00EA4E, "r16_mulhu");
    run(1'b1, 3'b000, 32'hFFFFFFFF, 32'hFFFFFFFF, 5'd22, 32'h00000001, "r16_mul");
    run(1'b1, 3'b001, 32'hFFFFFFF0, 32'h00000010, 5'd23, 32'hFFFFFFFF, "r16_mulh");
    run(1'b1, 3'b000, 32'd0, 32'd5, 5'd24, 32'h00000000, "r16_zero");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
    $finish;
  end
endmodule
